// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: AXI4-Lite bus between the memory arbiter and the memory slave.
//
// Handshake semantics (all five channels): a transfer happens on the rising
// edge where both VALID and READY are high. The sender holds VALID and its
// payload stable until that edge. VALID never waits on READY. READY may depend
// on VALID.
//
// Modports:
//   master - arbiter side: drives AR/AW/W payload+valid and R/B ready.
//   slave  - memory side: drives AR/AW/W ready and R/B payload+valid.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   axi_araddr;
  logic                axi_arvalid;
  logic                axi_arready;
  logic [DATA_W-1:0]   axi_rdata;
  logic [1:0]          axi_rresp;
  logic                axi_rvalid;
  logic                axi_rready;
  logic [ADDR_W-1:0]   axi_awaddr;
  logic                axi_awvalid;
  logic                axi_awready;
  logic [DATA_W-1:0]   axi_wdata;
  logic [DATA_W/8-1:0] axi_wstrb;
  logic                axi_wvalid;
  logic                axi_wready;
  logic [1:0]          axi_bresp;
  logic                axi_bvalid;
  logic                axi_bready;

  modport master (
    output axi_araddr, axi_arvalid, input axi_arready,
    input  axi_rdata, axi_rresp, axi_rvalid, output axi_rready,
    output axi_awaddr, axi_awvalid, input axi_awready,
    output axi_wdata, axi_wstrb, axi_wvalid, input axi_wready,
    input  axi_bresp, axi_bvalid, output axi_bready
  );

  modport slave (
    input  axi_araddr, axi_arvalid, output axi_arready,
    output axi_rdata, axi_rresp, axi_rvalid, input axi_rready,
    input  axi_awaddr, axi_awvalid, output axi_awready,
    input  axi_wdata, axi_wstrb, axi_wvalid, output axi_wready,
    output axi_bresp, axi_bvalid, input axi_bready
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one AXI4-Lite port between the fetch unit (IFU, read
// only) and the load/store unit (LSU, read/write). One transaction is in
// flight at a time. Simultaneous requests go round-robin.
//
// Ports:
//   clk_i, rst_i      - clock, synchronous active-high reset
//   ifu_req_*/ifu_addr - IFU request (valid/ready)
//   ifu_rsp_*/ifu_rdata - IFU one-cycle response pulse, data, error
//   lsu_req_*/lsu_we/lsu_addr/lsu_wdata/lsu_wstrb - LSU request
//   lsu_rsp_*/lsu_rdata - LSU one-cycle response pulse, data (0 on writes), error
//   axi               - AXI4-Lite master side (mem_arbiter_if.master)
//   state_o           - current FSM state, for observation
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_rsp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic                lsu_we,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_rsp_err,
  mem_arbiter_if.master       axi,
  output logic [2:0]          state_o
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW_W = 3'd3,
    S_B    = 3'd4
  } state_t;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [DATA_W-1:0]   ifu_rdata_q, ifu_rdata_d;
  logic                ifu_err_q, ifu_err_d;
  logic                ifu_rsp_valid_q, ifu_rsp_valid_d;
  logic [DATA_W-1:0]   lsu_rdata_q, lsu_rdata_d;
  logic                lsu_err_q, lsu_err_d;
  logic                lsu_rsp_valid_q, lsu_rsp_valid_d;

  logic grant_ifu, grant_lsu;
  logic arvalid, rready, awvalid, wvalid, bready;
  logic aw_fire, w_fire;

  // On a tie the unit that did not win last time goes first.
  assign grant_ifu = ifu_req_valid && (!lsu_req_valid || (last_grant_q == OWN_LSU));
  assign grant_lsu = lsu_req_valid && (!ifu_req_valid || (last_grant_q == OWN_IFU));

  assign aw_fire = (state_q == S_AW_W) && !aw_done_q && axi.axi_awready;
  assign w_fire  = (state_q == S_AW_W) && !w_done_q  && axi.axi_wready;

  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    owner_d         = owner_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    wstrb_d         = wstrb_q;
    aw_done_d       = aw_done_q;
    w_done_d        = w_done_q;
    ifu_rdata_d     = ifu_rdata_q;
    ifu_err_d       = ifu_err_q;
    ifu_rsp_valid_d = 1'b0;
    lsu_rdata_d     = lsu_rdata_q;
    lsu_err_d       = lsu_err_q;
    lsu_rsp_valid_d = 1'b0;
    ifu_req_ready   = 1'b0;
    lsu_req_ready   = 1'b0;
    arvalid         = 1'b0;
    rready          = 1'b0;
    awvalid         = 1'b0;
    wvalid          = 1'b0;
    bready          = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        ifu_req_ready = grant_ifu;
        lsu_req_ready = grant_lsu;
        if (grant_ifu) begin
          owner_d      = OWN_IFU;
          last_grant_d = OWN_IFU;
          addr_d       = ifu_addr;
          wdata_d      = '0;
          wstrb_d      = '0;
          state_d      = S_AR;
        end else if (grant_lsu) begin
          owner_d      = OWN_LSU;
          last_grant_d = OWN_LSU;
          addr_d       = lsu_addr;
          wdata_d      = lsu_wdata;
          wstrb_d      = lsu_wstrb;
          // Direction is carried by the next state; no separate we register.
          state_d      = lsu_we ? S_AW_W : S_AR;
        end
      end

      S_AR: begin
        arvalid = 1'b1;
        if (axi.axi_arready) state_d = S_R;
      end

      S_R: begin
        rready = 1'b1;
        if (axi.axi_rvalid) begin
          state_d = S_IDLE;
          if (owner_q == OWN_IFU) begin
            ifu_rdata_d     = axi.axi_rdata;
            ifu_err_d       = (axi.axi_rresp != 2'b00);
            ifu_rsp_valid_d = 1'b1;
          end else begin
            lsu_rdata_d     = axi.axi_rdata;
            lsu_err_d       = (axi.axi_rresp != 2'b00);
            lsu_rsp_valid_d = 1'b1;
          end
        end
      end

      S_AW_W: begin
        // AW and W are independent: each valid drops once its own beat is taken.
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
        if (aw_fire) aw_done_d = 1'b1;
        if (w_fire)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
          state_d   = S_B;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end

      S_B: begin
        bready = 1'b1;
        if (axi.axi_bvalid) begin
          state_d = S_IDLE;
          if (owner_q == OWN_IFU) begin
            ifu_rdata_d     = '0;
            ifu_err_d       = (axi.axi_bresp != 2'b00);
            ifu_rsp_valid_d = 1'b1;
          end else begin
            lsu_rdata_d     = '0;
            lsu_err_d       = (axi.axi_bresp != 2'b00);
            lsu_rsp_valid_d = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= S_IDLE;
      last_grant_q    <= OWN_LSU;
      owner_q         <= OWN_IFU;
      addr_q          <= '0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      aw_done_q       <= 1'b0;
      w_done_q        <= 1'b0;
      ifu_rdata_q     <= '0;
      ifu_err_q       <= 1'b0;
      ifu_rsp_valid_q <= 1'b0;
      lsu_rdata_q     <= '0;
      lsu_err_q       <= 1'b0;
      lsu_rsp_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      owner_q         <= owner_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      wstrb_q         <= wstrb_d;
      aw_done_q       <= aw_done_d;
      w_done_q        <= w_done_d;
      ifu_rdata_q     <= ifu_rdata_d;
      ifu_err_q       <= ifu_err_d;
      ifu_rsp_valid_q <= ifu_rsp_valid_d;
      lsu_rdata_q     <= lsu_rdata_d;
      lsu_err_q       <= lsu_err_d;
      lsu_rsp_valid_q <= lsu_rsp_valid_d;
    end
  end

  // Request payload comes straight from the latched registers, so it holds
  // stable across any slave stall.
  assign axi.axi_araddr  = addr_q;
  assign axi.axi_arvalid = arvalid;
  assign axi.axi_rready  = rready;
  assign axi.axi_awaddr  = addr_q;
  assign axi.axi_awvalid = awvalid;
  assign axi.axi_wdata   = wdata_q;
  assign axi.axi_wstrb   = wstrb_q;
  assign axi.axi_wvalid  = wvalid;
  assign axi.axi_bready  = bready;

  assign ifu_rsp_valid = ifu_rsp_valid_q;
  assign ifu_rdata     = ifu_rdata_q;
  assign ifu_rsp_err   = ifu_err_q;
  assign lsu_rsp_valid = lsu_rsp_valid_q;
  assign lsu_rdata     = lsu_rdata_q;
  assign lsu_rsp_err   = lsu_err_q;
  assign state_o       = state_q;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master to one-slave memory arbiter sitting between the fetch unit (IFU) and load/store unit (LSU) on one side and the core's single AXI4-Lite memory port on the other. It accepts simple valid/ready requests from both units, grants one at a time with round-robin tie-breaking, and sequences the AXI read (AR/R) or write (AW/W/B) channels. It returns data and error status to the owning unit. It replaces the two independent memory paths with one shared, sequenced port.

## Interface
- ADDR_W, default 32, address width (core xlen)
- DATA_W, default 32, data width; strobe width is DATA_W/8
- clk_i  in  1  clock, all logic rising-edge
- rst_i  in  1  synchronous, active-high reset
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  fetch address
- ifu_rsp_valid  out  1  one-cycle pulse, response available
- ifu_rdata  out  DATA_W  fetched word
- ifu_rsp_err  out  1  AXI RRESP != OKAY, valid with ifu_rsp_valid
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_we  in  1  1 = write, 0 = read
- lsu_addr  in  ADDR_W  load/store address
- lsu_wdata  in  DATA_W  store data
- lsu_wstrb  in  DATA_W/8  store byte mask
- lsu_rsp_valid  out  1  one-cycle pulse, response available
- lsu_rdata  out  DATA_W  load data; 0 for writes
- lsu_rsp_err  out  1  RRESP/BRESP != OKAY
- axi_araddr out ADDR_W, axi_arvalid out 1, axi_arready in 1: read-address channel
- axi_rdata in DATA_W, axi_rresp in 2, axi_rvalid in 1, axi_rready out 1: read-data channel
- axi_awaddr out ADDR_W, axi_awvalid out 1, axi_awready in 1: write-address channel
- axi_wdata out DATA_W, axi_wstrb out DATA_W/8, axi_wvalid in/out: wvalid out 1, wready in 1: write-data channel
- axi_bresp in 2, axi_bvalid in 1, axi_bready out 1: write-response channel

## Operation
- FSM states: IDLE, AR, R, AW_W, B. One transaction outstanding, no pipelining.
- IDLE arbitration:
  - only one valid: that master wins.
  - both valid: master not granted last time wins.
  - last_grant register resets to LSU, so the first tie goes to IFU.
- Grant: the winner's req_ready is asserted combinationally in IDLE; the loser's is 0. Both are 0 outside IDLE.
- On handshake, latch owner, we (IFU always 0), addr, wdata and wstrb; update last_grant. Next state is AR if read, AW_W if write.
- AR:
  - arvalid=1 and araddr=latched addr, held stable until arready.
  - On arready, go to R.
- R:
  - rready=1.
  - On rvalid, register rdata into the owner's rdata and set err = (rresp != 0); go to IDLE.
- AW_W:
  - awvalid and wvalid both assert from state entry.
  - aw_done and w_done flags each drop their valid independently after its handshake; channels may complete in either order or together.
  - Go to B when both done (flags cleared on leaving).
- B:
  - bready=1.
  - On bvalid, set err = (bresp != 0) and rdata = 0; go to IDLE.
- Response:
  - The owner's rsp_valid is a registered one-cycle pulse in the cycle after the R/B handshake, in which the FSM is already IDLE.
  - Units must accept it unconditionally (no backpressure).
  - rdata/err hold their values until the next response to that unit.

## Timing
- Reset values:
  - state=IDLE, last_grant=LSU.
  - All AXI valid/ready outputs 0; both rsp_valid 0.
  - Both rdata 0; both rsp_err 0.
  - araddr/awaddr/wdata/wstrb 0.
- Read, zero-wait slave: req handshake at cycle 0; arvalid cycle 1; rready/rvalid cycle 2; rsp_valid cycle 3. Minimum 3 cycles request-to-response.
- Write, zero-wait slave: AW+W at cycle 1, B at cycle 2, rsp_valid cycle 3.
- rsp_valid cycle is IDLE: a new request is grantable in the same cycle as the previous response.
- Back-to-back contention alternates grants: IFU, LSU, IFU...
- A request that is not granted must hold valid. The arbiter never drops a held request, which bounds starvation to one transaction.
- Slave stalls (arready/rvalid/awready/wready/bvalid low) extend the corresponding state indefinitely; outputs stay stable.
- Reset mid-transaction:
  - FSM returns to IDLE next edge and all valids drop.
  - No response is generated for the aborted transaction.
  - The slave shares rst_i.

## Test plan
- IFU read 0x8000_0000, slave returns 0x0000_0413 with zero wait -> ifu_rsp_valid pulses at cycle 3 with ifu_rdata=0x0000_0413, err=0; lsu_rsp_valid stays 0.
- LSU write addr 0x8000_0100, wdata 0xDEAD_BEEF, wstrb 0x3; slave takes W two cycles before AW -> AW/W each seen once; lsu_rsp_valid pulses one cycle after B with lsu_rdata=0.
- Both request every cycle from reset -> grants IFU, LSU, IFU, LSU; no request lost; each response carries its own address's data.
- Slave returns rresp=2'b10 on an LSU read -> lsu_rsp_err=1 for that response; a following OKAY read gives err=0.
- arready held low 5 cycles -> araddr/arvalid stable throughout; response arrives 3+5 cycles after the handshake.
- rst_i asserted while in R -> next cycle state IDLE, all AXI valids 0, no rsp_valid; the first tie after reset is granted to IFU.
